// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the DDS sweep controller.
//   - default tuning-word and dwell widths
//   - Avalon register word offsets
//   - CTRL / STATUS bit positions
//   - sweep FSM state encoding
package dds_pkg;

  localparam int PHASE_W_DEF = 10;
  localparam int DWELL_W_DEF = 16;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_START_TW = 3'd2;
  localparam logic [2:0] ADDR_STOP_TW  = 3'd3;
  localparam logic [2:0] ADDR_STEP_TW  = 3'd4;
  localparam logic [2:0] ADDR_DWELL    = 3'd5;
  localparam logic [2:0] ADDR_CUR_TW   = 3'd6;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/dds_sweep_regs.sv
// dds_sweep_regs: Avalon-MM register file for the sweep controller.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   avs_*             Avalon-MM slave (readdata registered, 1-cycle latency)
//   busy, cur_tw      live status from the sequencer (read-only registers)
//   done_set          one-cycle pulse from the sequencer at sweep completion
//   start_pulse       START written (and ABORT not written in the same word)
//   abort_pulse       ABORT written
//   loop_en, start_tw, stop_tw, step_tw, dwell   programmed configuration
//   irq               DONE sticky AND IRQ_EN
module dds_sweep_regs
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  input  logic               busy,
  input  logic [PHASE_W-1:0] cur_tw,
  input  logic               done_set,
  output logic               start_pulse,
  output logic               abort_pulse,
  output logic               loop_en,
  output logic [PHASE_W-1:0] start_tw,
  output logic [PHASE_W-1:0] stop_tw,
  output logic [PHASE_W-1:0] step_tw,
  output logic [DWELL_W-1:0] dwell,
  output logic               irq
);

  logic        wr_ctrl;
  logic        irq_en;
  logic        done;
  logic [31:0] rd_mux;
  logic        unused_wd;

  assign unused_wd = ^avs_writedata[31:DWELL_W];

  // START/ABORT are never stored: they act combinationally on the write
  // cycle so the sequencer enters LOAD on the same edge that takes the write.
  assign wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
  assign abort_pulse = wr_ctrl && avs_writedata[CTRL_ABORT];
  assign start_pulse = wr_ctrl && avs_writedata[CTRL_START] && !avs_writedata[CTRL_ABORT];

  assign irq = done && irq_en;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_LOOP]   = loop_en;
        rd_mux[CTRL_IRQ_EN] = irq_en;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
      end
      ADDR_START_TW: rd_mux[PHASE_W-1:0] = start_tw;
      ADDR_STOP_TW:  rd_mux[PHASE_W-1:0] = stop_tw;
      ADDR_STEP_TW:  rd_mux[PHASE_W-1:0] = step_tw;
      ADDR_DWELL:    rd_mux[DWELL_W-1:0] = dwell;
      ADDR_CUR_TW:   rd_mux[PHASE_W-1:0] = cur_tw;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_en      <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      start_tw     <= '0;
      stop_tw      <= '0;
      step_tw      <= '0;
      dwell        <= '0;
      avs_readdata <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          ADDR_CTRL: begin
            loop_en <= avs_writedata[CTRL_LOOP];
            irq_en  <= avs_writedata[CTRL_IRQ_EN];
          end
          ADDR_START_TW: start_tw <= avs_writedata[PHASE_W-1:0];
          ADDR_STOP_TW:  stop_tw  <= avs_writedata[PHASE_W-1:0];
          ADDR_STEP_TW:  step_tw  <= avs_writedata[PHASE_W-1:0];
          ADDR_DWELL:    dwell    <= avs_writedata[DWELL_W-1:0];
          default: ;
        endcase
      end
      // A completion in the same cycle as a W1C keeps DONE set.
      if (done_set) begin
        done <= 1'b1;
      end else if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[STAT_DONE]) begin
        done <= 1'b0;
      end
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: frequency-sweep sequencer for the DDS sine path.
// Steps the accumulator tuning word from START_TW towards STOP_TW by STEP_TW,
// holding each word for max(DWELL,1) cycles, clamping the last step to STOP_TW.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   avs_*             Avalon-MM register interface (see dds_sweep_regs)
//   tuning_word       phase increment to the accumulator
//   acc_enable        accumulator advance enable (high in RUN)
//   acc_clear         one-cycle accumulator clear (high in LOAD)
//   sweep_active      sequencer not IDLE
//   irq               level interrupt, DONE & IRQ_EN
module dds_sweep_controller
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         avs_address,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  output logic [PHASE_W-1:0] tuning_word,
  output logic               acc_enable,
  output logic               acc_clear,
  output logic               sweep_active,
  output logic               irq
);

  logic               start_pulse;
  logic               abort_pulse;
  logic               loop_en;
  logic [PHASE_W-1:0] start_tw;
  logic [PHASE_W-1:0] stop_tw;
  logic [PHASE_W-1:0] step_tw;
  logic [DWELL_W-1:0] dwell;
  logic               done_set;

  state_t             state;
  state_t             state_nxt;
  logic               load_go;
  logic               advance;

  logic [PHASE_W-1:0] stop_s;
  logic [PHASE_W-1:0] step_s;
  logic [DWELL_W-1:0] dwell_s;
  logic               single_s;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_last;
  logic               expire;
  logic               is_final;
  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] next_tw;

  dds_sweep_regs #(
    .PHASE_W (PHASE_W),
    .DWELL_W (DWELL_W)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .busy          (sweep_active),
    .cur_tw        (tuning_word),
    .done_set      (done_set),
    .start_pulse   (start_pulse),
    .abort_pulse   (abort_pulse),
    .loop_en       (loop_en),
    .start_tw      (start_tw),
    .stop_tw       (stop_tw),
    .step_tw       (step_tw),
    .dwell         (dwell),
    .irq           (irq)
  );

  assign acc_enable   = (state == RUN);
  assign acc_clear    = (state == LOAD);
  assign sweep_active = (state != IDLE);

  // DWELL of 0 behaves as 1.
  assign cnt_last = (dwell_s == '0) ? '0 : dwell_s - DWELL_W'(1);
  assign expire   = (cnt == cnt_last);
  assign is_final = single_s || (tuning_word == stop_s);

  // Extra carry bit catches wrap past the top of the phase range.
  assign sum     = {1'b0, tuning_word} + {1'b0, step_s};
  assign next_tw = (sum[PHASE_W] || (sum[PHASE_W-1:0] >= stop_s)) ? stop_s : sum[PHASE_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_go   = 1'b0;
    advance   = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          state_nxt = LOAD;
          load_go   = 1'b1;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (expire) begin
          if (!is_final) begin
            advance = 1'b1;
          end else if (loop_en) begin
            state_nxt = LOAD;
            load_go   = 1'b1;
          end else begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_pulse && (state != IDLE)) begin
      state_nxt = IDLE;
      load_go   = 1'b0;
      advance   = 1'b0;
      done_set  = 1'b0;
    end
  end

  // Config is shadowed on entry to LOAD, so the word is valid during LOAD itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      tuning_word <= '0;
      stop_s      <= '0;
      step_s      <= '0;
      dwell_s     <= '0;
      single_s    <= 1'b0;
      cnt         <= '0;
    end else begin
      if (load_go) begin
        tuning_word <= start_tw;
        stop_s      <= stop_tw;
        step_s      <= step_tw;
        dwell_s     <= dwell;
        single_s    <= (start_tw >= stop_tw) || (step_tw == '0);
      end else if (advance) begin
        tuning_word <= next_tw;
      end
      if ((state == RUN) && !expire) begin
        cnt <= cnt + DWELL_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
module tb_dds_sweep_controller;

  localparam int PW = 10;

  logic          clk;
  logic          rst;
  logic [2:0]    avs_address;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic          avs_read;
  logic [31:0]   avs_readdata;
  logic [PW-1:0] tuning_word;
  logic          acc_enable;
  logic          acc_clear;
  logic          sweep_active;
  logic          irq;

  int total = 0;
  int bad   = 0;
  int exp_w[$];
  logic [31:0] r;

  dds_sweep_controller #(.PHASE_W(PW), .DWELL_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .tuning_word   (tuning_word),
    .acc_enable    (acc_enable),
    .acc_clear     (acc_clear),
    .sweep_active  (sweep_active),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  // Expect the LOAD cycle: {active, enable, clear, word}
  task automatic check_load(input string tag, input int tw);
    chk(tag, 32'({sweep_active, acc_enable, acc_clear, tuning_word}),
        32'({1'b1, 1'b0, 1'b1, PW'(tw)}));
  endtask

  // Each word in exp_w held with acc_enable for d cycles
  task automatic run_words(input string tag, input int d);
    foreach (exp_w[i]) begin
      for (int j = 0; j < d; j++) begin
        tick();
        chk(tag, 32'({sweep_active, acc_enable, acc_clear, tuning_word}),
            32'({1'b1, 1'b1, 1'b0, PW'(exp_w[i])}));
      end
    end
  endtask

  task automatic check_done(input string tag, input int last, input logic exp_irq);
    logic [31:0] s;
    tick();
    chk(tag, 32'({sweep_active, acc_enable, acc_clear, irq, tuning_word}),
        32'({1'b0, 1'b0, 1'b0, exp_irq, PW'(last)}));
    rd(3'd1, s);
    chk({tag, "_status"}, s, 32'd2);
  endtask

  initial begin
    rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    tick(); tick(); tick();
    chk("reset_outs", 32'({tuning_word, acc_enable, acc_clear, sweep_active, irq}), 32'd0);
    chk("reset_rdata", avs_readdata, 32'd0);
    rst = 1'b0;

    // Basic sweep
    wr(3'd2, 100); wr(3'd3, 130); wr(3'd4, 10); wr(3'd5, 4);
    rd(3'd2, r); chk("rb_start", r, 100);
    rd(3'd3, r); chk("rb_stop", r, 130);
    rd(3'd4, r); chk("rb_step", r, 10);
    rd(3'd5, r); chk("rb_dwell", r, 4);
    rd(3'd1, r); chk("status_idle", r, 0);
    wr(3'd0, 1);
    check_load("basic_load", 100);
    exp_w = '{100, 110, 120, 130};
    run_words("basic_run", 4);
    check_done("basic_done", 130, 1'b0);
    rd(3'd6, r); chk("basic_cur", r, 130);
    wr(3'd1, 2);
    rd(3'd1, r); chk("w1c_done", r, 0);

    // Overshoot clamp, W1C coinciding with completion
    wr(3'd3, 125); wr(3'd5, 1);
    wr(3'd0, 1);
    check_load("clamp_load", 100);
    exp_w = '{100, 110, 120};
    run_words("clamp_run", 1);
    tick();
    chk("clamp_last", 32'({acc_enable, tuning_word}), 32'({1'b1, PW'(125)}));
    wr(3'd1, 2);
    chk("clamp_idle", 32'(sweep_active), 0);
    rd(3'd1, r); chk("set_wins", r, 2);
    wr(3'd1, 2);

    // Wrap guard near the top of the range
    wr(3'd2, 1000); wr(3'd3, 1023); wr(3'd4, 20);
    wr(3'd0, 1);
    check_load("wrap_load", 1000);
    exp_w = '{1000, 1020, 1023};
    run_words("wrap_run", 1);
    check_done("wrap_done", 1023, 1'b0);
    wr(3'd1, 2);

    // Degenerate: start >= stop
    wr(3'd2, 200); wr(3'd3, 100); wr(3'd4, 10); wr(3'd5, 3);
    wr(3'd0, 1);
    check_load("degen_load", 200);
    exp_w = '{200};
    run_words("degen_run", 3);
    check_done("degen_done", 200, 1'b0);
    wr(3'd1, 2);

    // Degenerate: step == 0
    wr(3'd2, 100); wr(3'd3, 130); wr(3'd4, 0);
    wr(3'd0, 1);
    check_load("step0_load", 100);
    exp_w = '{100};
    run_words("step0_run", 3);
    check_done("step0_done", 100, 1'b0);
    wr(3'd1, 2);

    // DWELL = 0 acts as 1
    wr(3'd4, 10); wr(3'd5, 0);
    wr(3'd0, 1);
    check_load("dw0_load", 100);
    exp_w = '{100, 110, 120, 130};
    run_words("dw0_run", 1);
    check_done("dw0_done", 130, 1'b0);
    wr(3'd1, 2);

    // Abort during the second word
    wr(3'd5, 4);
    wr(3'd0, 1);
    check_load("abort_load", 100);
    exp_w = '{100};
    run_words("abort_run", 4);
    tick();
    chk("abort_w2", 32'({acc_enable, tuning_word}), 32'({1'b1, PW'(110)}));
    wr(3'd0, 2);
    chk("abort_idle", 32'({sweep_active, acc_enable, acc_clear, tuning_word}),
        32'({1'b0, 1'b0, 1'b0, PW'(110)}));
    rd(3'd6, r); chk("abort_cur", r, 110);
    rd(3'd1, r); chk("abort_status", r, 0);

    // START and ABORT together: nothing starts
    wr(3'd0, 3);
    chk("start_abort", 32'({sweep_active, acc_clear}), 0);

    // START while busy is ignored
    wr(3'd0, 1);
    check_load("busy_load", 100);
    tick(); tick();
    wr(3'd0, 1);
    chk("busy_c2", 32'({acc_clear, acc_enable, tuning_word}), 32'({1'b0, 1'b1, PW'(100)}));
    tick();
    chk("busy_c3", 32'({acc_clear, acc_enable, tuning_word}), 32'({1'b0, 1'b1, PW'(100)}));
    tick();
    chk("busy_w2", 32'({acc_clear, acc_enable, tuning_word}), 32'({1'b0, 1'b1, PW'(110)}));
    wr(3'd0, 2);

    // Loop mode with IRQ enabled
    wr(3'd2, 0); wr(3'd3, 20); wr(3'd4, 10); wr(3'd5, 2);
    wr(3'd0, 13);
    check_load("loop_load0", 0);
    exp_w = '{0, 10, 20};
    run_words("loop_p1", 2);
    tick();
    check_load("loop_load1", 0);
    chk("loop_noirq", 32'(irq), 0);
    run_words("loop_p2", 2);
    tick();
    check_load("loop_load2", 0);
    tick();
    chk("loop_w0a", 32'({acc_enable, tuning_word}), 32'({1'b1, PW'(0)}));
    wr(3'd0, 8);
    chk("loop_w0b", 32'({acc_enable, tuning_word}), 32'({1'b1, PW'(0)}));
    exp_w = '{10, 20};
    run_words("loop_last", 2);
    check_done("loop_done", 20, 1'b1);
    wr(3'd1, 2);
    chk("irq_w1c", 32'(irq), 0);
    rd(3'd1, r); chk("irq_status", r, 0);

    // Synchronous reset mid-RUN
    wr(3'd2, 100); wr(3'd3, 130); wr(3'd4, 10); wr(3'd5, 4);
    wr(3'd0, 9);
    tick(); tick();
    chk("pre_rst_run", 32'(acc_enable), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst", 32'({tuning_word, acc_enable, acc_clear, sweep_active, irq}), 32'd0);
    rst = 1'b0;
    rd(3'd2, r); chk("rst_start_tw", r, 0);
    rd(3'd0, r); chk("rst_ctrl", r, 0);

    // Readback masking and unused locations
    wr(3'd2, 32'hFFFF_FFFF); rd(3'd2, r); chk("mask_start", r, 32'h3FF);
    wr(3'd3, 17);            rd(3'd3, r); chk("rb_stop2", r, 17);
    wr(3'd4, 5);             rd(3'd4, r); chk("rb_step2", r, 5);
    wr(3'd5, 32'h1234_ABCD); rd(3'd5, r); chk("mask_dwell", r, 32'hABCD);
    wr(3'd0, 15);
    chk("ctrl15_idle", 32'(sweep_active), 0);
    rd(3'd0, r); chk("rb_ctrl", r, 12);
    rd(3'd7, r); chk("rb_addr7", r, 0);
    rd(3'd6, r); chk("rb_cur0", r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
